fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the pipelined MIPS datapath. It owns the PC register, drives the instruction-memory address, and computes the next PC from sequential, branch, jump and jump-register requests raised by the decode stage. It also maintains the IF/ID pipeline register, including the valid bit, stall hold and redirect flush, and a retired-fetch counter. It replaces the standalone PC plus combinational next-PC pair: decode supplies the redirect requests, and this block decides the actual NextPC.

## Interface
Parameters:
- RESET_PC, 32'h00003000: byte address of the first fetch. Bits [1:0] must be 0.

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  synchronous reset, active-high
- ImAddr  out  [31:2]  instruction-memory word address (= PC)
- ImData  in  [31:0]  instruction word; combinational read of ImAddr
- Stall  in  1  hazard-unit hold of PC and IF/ID
- BranchTaken  in  1  decode-stage branch resolved taken
- BranchOffset  in  [15:0]  signed word offset of the branch
- Jump  in  1  j/jal in decode
- JumpIndex  in  [25:0]  instr_index field
- JumpReg  in  1  jr/jalr in decode
- JumpRegAddr  in  [31:2]  rs value, word address
- IfIdInstr  out  [31:0]  latched instruction
- IfIdPC4  out  [31:2]  latched PC+1 word
- IfIdValid  out  1  IF/ID holds a real instruction
- FetchCount  out  [31:0]  number of valid instructions latched into IF/ID

## Operation
- PC is a 30-bit register. ImAddr = PC at all times.
- Redirect = JumpReg | Jump | BranchTaken. Target priority: JumpReg > Jump > BranchTaken.
  - JumpReg: target = JumpRegAddr.
  - Jump: target = {IfIdPC4[31:28], JumpIndex}.
  - Branch: target = IfIdPC4 + sign-extended BranchOffset (30 bits), modulo 2^30.
- Sequential target is PC + 1, modulo 2^30. Wrap from 30'h3FFFFFFF to 0 is legal and must not be flagged.
- Next-state priority per edge:
  - Reset: PC = RESET_PC[31:2]; IfIdInstr = 0; IfIdPC4 = 0; IfIdValid = 0; FetchCount = 0.
  - Stall: PC, IfIdInstr, IfIdPC4, IfIdValid and FetchCount all hold. A simultaneous redirect is ignored. Decode holds its instruction, so it re-asserts the redirect after the stall.
  - Redirect: PC = target; IfIdValid = 0 (flush the wrong-path fetch); IfIdInstr and IfIdPC4 are loaded but are don't-care. FetchCount holds. There is no delay slot.
  - Otherwise: PC = PC + 1; IfIdInstr = ImData; IfIdPC4 = PC + 1; IfIdValid = 1; FetchCount += 1.
- Redirect inputs are qualified only when IfIdValid = 1. When IfIdValid = 0 they are ignored and the edge behaves as sequential.
- FetchCount wraps from 32'hFFFFFFFF to 0.
- Multiple redirect inputs high at once is a decode error. The priority above is still applied deterministically.

## Timing
- All state updates on the rising edge of Clk. There are no combinational paths from inputs to outputs except ImData → (register) → IfIdInstr.
- During Reset high: ImAddr = RESET_PC[31:2], IfIdValid = 0, FetchCount = 0. Reset asserted mid-stream overrides Stall and redirect on that edge.
- First edge after Reset deasserts: IF/ID captures the word at 0x3000 (IfIdPC4 = 0x3004 >> 2) and ImAddr becomes 0x3004 >> 2.
- Redirect penalty: exactly one bubble. On edge N the redirect is seen. After edge N, ImAddr = target and IfIdValid = 0. After edge N+1, IF/ID holds the target instruction with IfIdValid = 1.
- Stall held for k cycles leaves all outputs unchanged for exactly k edges.

## Test plan
- Reset then 4 free-running cycles, with ImData = word address × 4 → after the 4th edge: ImAddr = 0x3010 >> 2, IfIdInstr = 0x300C, IfIdValid = 1, FetchCount = 4.
- Backward branch: IfIdPC4 = 0x3010 >> 2, BranchTaken = 1, BranchOffset = 16'hFFFC → next ImAddr = 0x3000 >> 2, IfIdValid = 0, FetchCount unchanged. One edge later: IfIdValid = 1 with the instruction at 0x3000.
- Jump with IfIdPC4 = 0x3008 >> 2, JumpIndex = 26'h0000C10 → ImAddr = 0x3040 >> 2. Jump and JumpReg together (JumpRegAddr = 0x4000 >> 2) → ImAddr = 0x4000 >> 2.
- Stall for 3 cycles with BranchTaken = 1 → PC, IF/ID and FetchCount frozen for 3 edges. On the first unstalled edge the branch is taken.
- Reset asserted while Stall = 1 and JumpReg = 1 → ImAddr = 0x3000 >> 2, IfIdValid = 0, FetchCount = 0 after that edge.
- Redirect with IfIdValid = 0 (the cycle directly after a flush) → ignored; PC increments sequentially. PC = 30'h3FFFFFFF sequential → wraps to 0.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC register, next-PC selection, IF/ID
// pipeline register with stall/flush, and a count of valid fetches.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic [31:2] ImAddr,
  input  logic [31:0] ImData,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchOffset,
  input  logic        Jump,
  input  logic [25:0] JumpIndex,
  input  logic        JumpReg,
  input  logic [31:2] JumpRegAddr,
  output logic [31:0] IfIdInstr,
  output logic [31:2] IfIdPC4,
  output logic        IfIdValid,
  output logic [31:0] FetchCount
);

  logic [31:2] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:2] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;

  logic        redirect;
  logic [31:2] pc_seq;
  logic [31:2] branch_target;
  logic [31:2] target;

  // Redirects come from the instruction in decode, so they only count
  // when IF/ID actually holds a real instruction.
  assign redirect      = IfIdValid & (JumpReg | Jump | BranchTaken);
  assign pc_seq        = pc_q + 30'd1;
  assign branch_target = pc4_q + {{14{BranchOffset[15]}}, BranchOffset};

  always_comb begin
    target = branch_target;
    if (JumpReg)
      target = JumpRegAddr;
    else if (Jump)
      target = {pc4_q[31:28], JumpIndex};
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    count_d = count_q;
    if (!Stall) begin
      instr_d = ImData;
      pc4_d   = pc_seq;
      if (redirect) begin
        pc_d    = target;
        valid_d = 1'b0;
      end else begin
        pc_d    = pc_seq;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q    <= RESET_PC[31:2];
      instr_q <= 32'd0;
      pc4_q   <= 30'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign ImAddr     = pc_q;
  assign IfIdInstr  = instr_q;
  assign IfIdPC4    = pc4_q;
  assign IfIdValid  = valid_q;
  assign FetchCount = count_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a behavioural model pushes the expected
// state for every driven cycle; it is popped and compared after the edge.
module tb_fetch_ctrl;

  logic        Clk;
  logic        Reset;
  logic [31:2] ImAddr;
  logic [31:0] ImData;
  logic        Stall;
  logic        BranchTaken;
  logic [15:0] BranchOffset;
  logic        Jump;
  logic [25:0] JumpIndex;
  logic        JumpReg;
  logic [31:2] JumpRegAddr;
  logic [31:0] IfIdInstr;
  logic [31:2] IfIdPC4;
  logic        IfIdValid;
  logic [31:0] FetchCount;

  fetch_ctrl #(.RESET_PC(32'h0000_3000)) dut (
    .Clk(Clk), .Reset(Reset), .ImAddr(ImAddr), .ImData(ImData),
    .Stall(Stall), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .Jump(Jump), .JumpIndex(JumpIndex), .JumpReg(JumpReg),
    .JumpRegAddr(JumpRegAddr), .IfIdInstr(IfIdInstr), .IfIdPC4(IfIdPC4),
    .IfIdValid(IfIdValid), .FetchCount(FetchCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Instruction memory content: each word holds its own byte address.
  assign ImData = {ImAddr, 2'b00};

  typedef struct {
    logic [29:0] pc;
    logic [31:0] instr;
    logic [29:0] pc4;
    logic        valid;
    logic [31:0] count;
    logic        data_known;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  logic [29:0] m_pc;
  logic [31:0] m_instr;
  logic [29:0] m_pc4;
  logic        m_valid;
  logic [31:0] m_count;
  logic        m_known;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d obs=%h exp=%h", tag, txn, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stl, input logic br,
                      input logic [15:0] off, input logic j, input logic [25:0] idx,
                      input logic jr, input logic [29:0] jra);
    exp_t e;
    logic [29:0] tgt;
    @(negedge Clk);
    Reset = rst; Stall = stl; BranchTaken = br; BranchOffset = off;
    Jump = j; JumpIndex = idx; JumpReg = jr; JumpRegAddr = jra;
    if (jr)      tgt = jra;
    else if (j)  tgt = {m_pc4[29:26], idx};
    else         tgt = m_pc4 + {{14{off[15]}}, off};
    if (rst) begin
      m_pc = 30'h0C00; m_instr = 32'd0; m_pc4 = 30'd0;
      m_valid = 1'b0; m_count = 32'd0; m_known = 1'b1;
    end else if (stl) begin
      // everything holds
    end else if (m_valid && (jr || j || br)) begin
      m_pc = tgt; m_valid = 1'b0; m_known = 1'b0;
    end else begin
      m_instr = {m_pc, 2'b00}; m_pc4 = m_pc + 30'd1; m_pc = m_pc + 30'd1;
      m_valid = 1'b1; m_count = m_count + 32'd1; m_known = 1'b1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid;
    e.count = m_count; e.data_known = m_known;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    txn++;
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("imaddr", {2'b00, ImAddr}, {2'b00, e.pc});
      chk("valid", {31'd0, IfIdValid}, {31'd0, e.valid});
      chk("count", FetchCount, e.count);
      if (e.data_known) begin
        chk("instr", IfIdInstr, e.instr);
        chk("pc4", {2'b00, IfIdPC4}, {2'b00, e.pc4});
      end
      $display("txn %0d rst=%0b stall=%0b br=%0b j=%0b jr=%0b -> ImAddr=%h valid=%0b count=%0d",
               txn, rst, stl, br, j, jr, ImAddr, IfIdValid, FetchCount);
    end
  endtask

  task automatic free(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'd0, 0, 26'd0, 0, 30'd0);
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchOffset = 16'd0;
    Jump = 1'b0; JumpIndex = 26'd0; JumpReg = 1'b0; JumpRegAddr = 30'd0;
    m_pc = 30'd0; m_instr = 32'd0; m_pc4 = 30'd0; m_valid = 1'b0;
    m_count = 32'd0; m_known = 1'b0;

    step(1, 0, 0, 16'd0, 0, 26'd0, 0, 30'd0);
    step(1, 0, 0, 16'd0, 0, 26'd0, 0, 30'd0);
    chk("reset_imaddr", {2'b00, ImAddr}, 32'h3000 >> 2);
    chk("reset_valid", {31'd0, IfIdValid}, 32'd0);
    chk("reset_count", FetchCount, 32'd0);

    free(4);
    chk("run4_imaddr", {2'b00, ImAddr}, 32'h3010 >> 2);
    chk("run4_instr", IfIdInstr, 32'h0000_300C);
    chk("run4_count", FetchCount, 32'd4);

    // Backward branch from IfIdPC4 = 0x3010 to 0x3000
    step(0, 0, 1, 16'hFFFC, 0, 26'd0, 0, 30'd0);
    chk("bbr_imaddr", {2'b00, ImAddr}, 32'h3000 >> 2);
    chk("bbr_valid", {31'd0, IfIdValid}, 32'd0);
    chk("bbr_count", FetchCount, 32'd4);
    free(1);
    chk("bbr_instr", IfIdInstr, 32'h0000_3000);
    chk("bbr_valid2", {31'd0, IfIdValid}, 32'd1);

    free(1);
    step(0, 0, 0, 16'd0, 1, 26'h0000C10, 0, 30'd0);
    chk("jump_imaddr", {2'b00, ImAddr}, 32'h3040 >> 2);
    free(1);
    step(0, 0, 0, 16'd0, 1, 26'h0000C10, 1, 30'h0000_1000);
    chk("jr_prio_imaddr", {2'b00, ImAddr}, 32'h4000 >> 2);
    free(2);

    // Stall for three edges with a pending branch, then take it
    for (int i = 0; i < 3; i++) step(0, 1, 1, 16'd8, 0, 26'd0, 0, 30'd0);
    step(0, 0, 1, 16'd8, 0, 26'd0, 0, 30'd0);
    chk("stall_br_imaddr", {2'b00, ImAddr}, (32'h4008 >> 2) + 32'd8);
    free(3);

    step(1, 1, 0, 16'd0, 0, 26'd0, 1, 30'h0000_2000);
    chk("rst_ovr_imaddr", {2'b00, ImAddr}, 32'h3000 >> 2);
    chk("rst_ovr_count", FetchCount, 32'd0);
    free(2);

    // Redirect to the top word, then an unqualified redirect must be ignored
    step(0, 0, 0, 16'd0, 0, 26'd0, 1, 30'h3FFF_FFFF);
    step(0, 0, 0, 16'd0, 0, 26'd0, 1, 30'h0000_0123);
    chk("wrap_imaddr", {2'b00, ImAddr}, 32'd0);
    chk("wrap_instr", IfIdInstr, 32'hFFFF_FFFC);
    chk("wrap_pc4", {2'b00, IfIdPC4}, 32'd0);
    free(1);

    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 6) == 0), 16'($urandom),
           ($urandom_range(0, 9) == 0), 26'($urandom),
           ($urandom_range(0, 11) == 0), 30'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
